// File: rtl/img_pkg.sv
// Shared image geometry, pixel type and FSM state encoding for the window fetcher.
package img_pkg;

    localparam int unsigned IMG_W  = 800;
    localparam int unsigned IMG_H  = 600;
    localparam int unsigned STRIDE = IMG_W + 2;
    localparam int unsigned AW     = 19;
    localparam int unsigned OW     = 19;

    typedef logic [7:0] pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/win_addr_gen.sv
// Raster position tracker: holds the window base pointer and column/row counters and
// derives the nine 3x3 neighbourhood addresses from them with constant offsets.
module win_addr_gen
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = img_pkg::IMG_W,
    parameter int unsigned IMG_H = img_pkg::IMG_H,
    parameter int unsigned AW    = img_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          advance,
    output logic [AW-1:0] addr [9],
    output logic          is_last
);

    localparam int unsigned RowPitch = IMG_W + 2;
    localparam int unsigned CW       = $clog2(IMG_W + 1);
    localparam int unsigned RW       = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] ColLast = CW'(IMG_W);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H);

    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Offsets are elaboration-time constants, so each address is a single adder.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                addr[3*r+c] = base_q + AW'(r * RowPitch + c);
            end
        end
    end

    assign is_last = (row_q == RowLast) && (col_q == ColLast);

    always_comb begin
        base_d = base_q;
        col_d  = col_q;
        row_d  = row_q;
        if (init) begin
            base_d = '0;
            col_d  = CW'(1);
            row_d  = RW'(1);
        end else if (advance) begin
            if (col_q != ColLast) begin
                base_d = base_q + AW'(1);
                col_d  = col_q + CW'(1);
            end else begin
                // Skip the right border of this row and the left border of the next.
                base_d = base_q + AW'(3);
                col_d  = CW'(1);
                row_d  = row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            col_q  <= CW'(1);
            row_q  <= RW'(1);
        end else begin
            base_q <= base_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/window_fetch.sv
// Frame raster scanner: drives 3x3 window addresses into a combinational image memory,
// registers the returned bytes and offers one window per cycle over valid/ready.
module window_fetch
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = img_pkg::IMG_W,
    parameter int unsigned IMG_H = img_pkg::IMG_H,
    parameter int unsigned AW    = img_pkg::AW,
    parameter int unsigned OW    = img_pkg::OW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8,
    input  pix_t          v0, v1, v2, v3, v4, v5, v6, v7, v8,
    output pix_t          win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7,
    output pix_t          win_p8,
    output logic [OW-1:0] win_idx,
    output logic          win_last,
    output logic          win_valid,
    input  logic          win_ready,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    pix_t          win_p_q [9];
    pix_t          win_p_d [9];
    pix_t          v_arr [9];
    logic [OW-1:0] win_idx_q, win_idx_d, idx_q, idx_d;
    logic          win_last_q, win_last_d, win_valid_q, win_valid_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          ag_init, ag_adv, ag_last, load;
    logic [AW-1:0] addr [9];

    win_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (ag_init),
        .advance (ag_adv),
        .addr    (addr),
        .is_last (ag_last)
    );

    assign {a0, a1, a2, a3, a4, a5, a6, a7, a8} =
        {addr[0], addr[1], addr[2], addr[3], addr[4], addr[5], addr[6], addr[7], addr[8]};
    assign {v_arr[0], v_arr[1], v_arr[2], v_arr[3], v_arr[4], v_arr[5], v_arr[6], v_arr[7],
            v_arr[8]} = {v0, v1, v2, v3, v4, v5, v6, v7, v8};
    assign {win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8} =
        {win_p_q[0], win_p_q[1], win_p_q[2], win_p_q[3], win_p_q[4], win_p_q[5], win_p_q[6],
         win_p_q[7], win_p_q[8]};

    assign win_idx   = win_idx_q;
    assign win_last  = win_last_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Refill whenever the output register is empty or is being drained this cycle.
    assign load = (state_q == FETCH) && (!win_valid_q || win_ready);

    always_comb begin
        state_d     = state_q;
        win_p_d     = win_p_q;
        win_idx_d   = win_idx_q;
        idx_d       = idx_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ag_init     = 1'b0;
        ag_adv      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ag_init = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (load) begin
                    win_p_d     = v_arr;
                    win_idx_d   = idx_q;
                    win_valid_d = 1'b1;
                    win_last_d  = ag_last;
                    idx_d       = idx_q + OW'(1);
                    if (ag_last) state_d = DRAIN;
                    else         ag_adv  = 1'b1;
                end
            end
            DRAIN: begin
                if (win_valid_q && win_ready) begin
                    win_valid_d = 1'b0;
                    win_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_p_q     <= '{default: '0};
            win_idx_q   <= '0;
            idx_q       <= '0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_p_q     <= win_p_d;
            win_idx_q   <= win_idx_d;
            idx_q       <= idx_d;
            win_last_q  <= win_last_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_window_fetch.sv
// Scoreboard bench for window_fetch on a 4x3 image with a combinational mem[i]=i[7:0].
module tb_window_fetch;

    localparam int W = 4;
    localparam int H = 3;
    localparam int S = W + 2;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        win_ready = 1'b1;
    logic [18:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [7:0]  v0, v1, v2, v3, v4, v5, v6, v7, v8;
    logic [7:0]  win_p0, win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8;
    logic [18:0] win_idx;
    logic        win_last, win_valid, busy, done;

    int n_pass = 0;
    int n_total = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_acc_cyc = -10;
    logic [91:0] exp_q [$];

    window_fetch #(
        .IMG_W (W),
        .IMG_H (H),
        .AW    (19),
        .OW    (19)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4), .a5 (a5), .a6 (a6), .a7 (a7),
        .a8 (a8),
        .v0 (v0), .v1 (v1), .v2 (v2), .v3 (v3), .v4 (v4), .v5 (v5), .v6 (v6), .v7 (v7),
        .v8 (v8),
        .win_p0 (win_p0), .win_p1 (win_p1), .win_p2 (win_p2), .win_p3 (win_p3),
        .win_p4 (win_p4), .win_p5 (win_p5), .win_p6 (win_p6), .win_p7 (win_p7),
        .win_p8 (win_p8),
        .win_idx (win_idx), .win_last (win_last), .win_valid (win_valid),
        .win_ready (win_ready), .busy (busy), .done (done)
    );

    function automatic logic [7:0] mem_rd(input logic [18:0] addr);
        return addr[7:0];
    endfunction

    assign v0 = mem_rd(a0);
    assign v1 = mem_rd(a1);
    assign v2 = mem_rd(a2);
    assign v3 = mem_rd(a3);
    assign v4 = mem_rd(a4);
    assign v5 = mem_rd(a5);
    assign v6 = mem_rd(a6);
    assign v7 = mem_rd(a7);
    assign v8 = mem_rd(a8);

    logic [170:0] addr_vec;
    logic [91:0]  win_vec;
    assign addr_vec = {a0, a1, a2, a3, a4, a5, a6, a7, a8};
    assign win_vec  = {win_idx, win_last, win_p0, win_p1, win_p2, win_p3, win_p4, win_p5,
                       win_p6, win_p7, win_p8};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: window k is centred on interior pixel (k/W+1, k%W+1) of the padded frame.
    function automatic int exp_addr(input int k, input int j);
        int r = k / W + 1;
        int c = k % W + 1;
        return (r - 1 + j / 3) * S + (c - 1 + j % 3);
    endfunction

    function automatic logic [170:0] exp_addrs(input int k);
        logic [170:0] v = '0;
        for (int j = 0; j < 9; j++) v[170-19*j -: 19] = 19'(exp_addr(k, j));
        return v;
    endfunction

    function automatic logic [91:0] exp_win(input int k);
        logic [91:0] w = '0;
        for (int j = 0; j < 9; j++) w[71-8*j -: 8] = 8'(exp_addr(k, j));
        w[72]     = (k == N - 1);
        w[91:73]  = 19'(k);
        return w;
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: pops the scoreboard on every accepted window and times the done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_window");
                end else begin
                    check("window", 192'(win_vec), 192'(exp_q.pop_front()));
                    if (win_last) last_acc_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_timing", 192'(cyc), 192'(last_acc_cyc + 1));
            end
        end
    end

    task automatic push_frame();
        for (int k = 0; k < N; k++) exp_q.push_back(exp_win(k));
    endtask

    // Entered and left at posedge+1.
    task automatic pulse_start(input bit expect_frame);
        start = 1'b1;
        if (expect_frame) push_frame();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) fail_now("wait_done");
    endtask

    task automatic wait_idx(input int k, input int budget);
        int n = 0;
        while (!(win_valid && win_idx == 19'(k)) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(win_valid && win_idx == 19'(k))) fail_now("wait_idx");
    endtask

    initial begin
        int d0;
        // 1: reset state, first window, full frame with ready held high
        rst_n = 1'b0;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 192'({win_valid, busy, done, win_last}), 192'(0));
        check("reset_regs", 192'({win_idx, win_p4}), 192'(0));
        check("reset_addr", 192'(addr_vec), 192'(exp_addrs(0)));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(1'b1);
        check("first_addr", 192'(addr_vec), 192'(exp_addrs(0)));
        check("first_busy_valid", 192'({busy, win_valid}), 192'(2'b10));
        @(posedge clk); #1;
        check("first_valid", 192'({win_valid, win_idx, win_p4}), 192'({1'b1, 19'd0, 8'd7}));
        wait_done(40);
        @(posedge clk); #1;
        check("after_done", 192'({busy, done}), 192'(0));
        check("done_count_1", 192'(done_cnt), 192'(1));

        // 3: backpressure at idx 5
        pulse_start(1'b1);
        wait_idx(5, 20);
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_hold", 192'({win_valid, win_vec, addr_vec}),
                  192'({1'b1, exp_win(5), exp_addrs(6)}));
        end
        win_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", 192'({win_valid, win_idx}), 192'({1'b1, 19'd6}));
        wait_done(40);
        @(posedge clk); #1;

        // 4: random ready over a full frame
        d0 = done_cnt;
        pulse_start(1'b1);
        begin
            int n = 0;
            while (!done && n < 300) begin
                win_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            if (!done) fail_now("random_frame");
        end
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("random_one_done", 192'(done_cnt - d0), 192'(1));
        check("random_drained", 192'(exp_q.size()), 192'(0));

        // 5: start ignored mid-frame, accepted in the done cycle
        pulse_start(1'b1);
        wait_idx(4, 20);
        pulse_start(1'b0);
        wait_done(40);
        pulse_start(1'b1);
        check("restart_in_done", 192'({busy, win_valid, addr_vec}),
              192'({2'b10, exp_addrs(0)}));
        wait_done(40);
        @(posedge clk); #1;

        // 6: asynchronous reset mid-frame
        pulse_start(1'b1);
        wait_idx(7, 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 192'({win_valid, busy, done}), 192'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start(1'b1);
        check("post_reset_a4", 192'(a4), 192'(7));
        wait_done(40);
        repeat (3) @(posedge clk);
        #1;
        check("total_done", 192'(done_cnt), 192'(6));
        check("scoreboard_empty", 192'(exp_q.size()), 192'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
